// File: rtl/meas_run_ctrl.sv
// Measurement run controller: turns host commands into gate start/stop/clr controls and times/counts each run.
// Optional photon counter is built only when MEAS_RUN_CTRL_PHOTON_CNT_EN is defined; otherwise photon_cnt reads 0.
module meas_run_ctrl #(
  parameter int TICK_W  = 32,
  parameter int CNT_W   = 32,
  parameter int CLR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [TICK_W-1:0] duration,
  input  logic              tick,
  input  logic              sin,
  output logic              start,
  output logic              stop,
  output logic              clr,
  output logic              running,
  output logic              done,
  output logic              cmd_err,
  output logic [TICK_W-1:0] elapsed,
  output logic [CNT_W-1:0]  photon_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  localparam int CW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_LEN - 1);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] dur_q, dur_d;
  logic [TICK_W-1:0] elapsed_q, elapsed_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              clr_q, running_q;

  logic cmd_acc;
  logic in_run;
  logic auto_stop;
  logic cnt_zero;

  assign cmd_ready = (state_q != CLEAR);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign in_run    = (state_q == RUN);
  assign auto_stop = in_run && tick && (dur_q != '0) && (elapsed_q == dur_q - TICK_W'(1));
  // Counters restart on a fresh start from IDLE and on any abort.
  assign cnt_zero  = cmd_acc && ((cmd_op == OP_ABORT) || ((state_q == IDLE) && (cmd_op == OP_START)));

  always_comb begin
    elapsed_d = elapsed_q;
    if (cnt_zero) begin
      elapsed_d = '0;
    end else if (in_run && tick && (elapsed_q != '1)) begin
      elapsed_d = elapsed_q + TICK_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    clr_cnt_d = clr_cnt_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          if (cmd_op == OP_START) begin
            dur_d     = duration;
            clr_cnt_d = CLR_LAST;
            state_d   = CLEAR;
          end else if (cmd_op == OP_STOP) begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d = RUN;
          start_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q - CW'(1);
        end
      end
      RUN: begin
        if (auto_stop) begin
          stop_d  = 1'b1;
          done_d  = 1'b1;
          state_d = HOLD;
        end
        // An abort overrides a coincident auto-stop, so no done is reported.
        if (cmd_acc) begin
          case (cmd_op)
            OP_START: err_d = 1'b1;
            OP_STOP: begin
              stop_d  = 1'b1;
              state_d = HOLD;
            end
            OP_ABORT: begin
              stop_d  = 1'b1;
              done_d  = 1'b0;
              state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_START: begin
              if ((dur_q != '0) && (elapsed_q >= dur_q)) begin
                err_d = 1'b1;
              end else begin
                start_d = 1'b1;
                state_d = RUN;
              end
            end
            OP_STOP:  err_d   = 1'b1;
            OP_ABORT: state_d = IDLE;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      elapsed_q <= '0;
      clr_cnt_q <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      elapsed_q <= elapsed_d;
      clr_cnt_q <= clr_cnt_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clr_q     <= (state_d == CLEAR);
      running_q <= (state_d == RUN);
    end
  end

`ifdef MEAS_RUN_CTRL_PHOTON_CNT_EN
  logic [CNT_W-1:0] photon_q, photon_d;

  always_comb begin
    photon_d = photon_q;
    if (cnt_zero) begin
      photon_d = '0;
    end else if (in_run && sin && (photon_q != '1)) begin
      photon_d = photon_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      photon_q <= '0;
    end else begin
      photon_q <= photon_d;
    end
  end

  assign photon_cnt = photon_q;
`else
  logic sin_unused;
  assign sin_unused = sin;
  assign photon_cnt = '0;
`endif

  assign start   = start_q;
  assign stop    = stop_q;
  assign clr     = clr_q;
  assign running = running_q;
  assign done    = done_q;
  assign cmd_err = err_q;
  assign elapsed = elapsed_q;
  assign state   = state_q;

endmodule

// File: tb/tb_meas_run_ctrl.sv
// Testbench for meas_run_ctrl: directed scenarios followed by random commands, checked against a run-level model.
module tb_meas_run_ctrl;

  localparam int TW  = 4;
  localparam int CNW = 4;
  localparam int CLR = 4;
  localparam int MAXT = (1 << TW) - 1;
  localparam int MAXC = (1 << CNW) - 1;

  localparam int OP_NOP   = 0;
  localparam int OP_START = 1;
  localparam int OP_STOP  = 2;
  localparam int OP_ABORT = 3;

  localparam int MS_IDLE  = 0;
  localparam int MS_CLEAR = 1;
  localparam int MS_RUN   = 2;
  localparam int MS_HOLD  = 3;

`ifdef MEAS_RUN_CTRL_PHOTON_CNT_EN
  localparam bit PHOT_EN = 1'b1;
`else
  localparam bit PHOT_EN = 1'b0;
`endif

  logic           clk;
  logic           rstN;
  logic           cmdValid;
  logic           cmdReady;
  logic [1:0]     cmdOp;
  logic [TW-1:0]  dur;
  logic           tick;
  logic           sin;
  logic           startP;
  logic           stopP;
  logic           clr;
  logic           running;
  logic           done;
  logic           cmdErr;
  logic [TW-1:0]  elapsed;
  logic [CNW-1:0] photonCnt;
  logic [1:0]     state;

  int testsRun;
  int testsFailed;

  int mState;
  int mDur;
  int mElapsed;
  int mPhot;
  int mClrLeft;
  bit eStart;
  bit eStop;
  bit eDone;
  bit eErr;

  meas_run_ctrl #(
    .TICK_W (TW),
    .CNT_W  (CNW),
    .CLR_LEN(CLR)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_op    (cmdOp),
    .duration  (dur),
    .tick      (tick),
    .sin       (sin),
    .start     (startP),
    .stop      (stopP),
    .clr       (clr),
    .running   (running),
    .done      (done),
    .cmd_err   (cmdErr),
    .elapsed   (elapsed),
    .photon_cnt(photonCnt),
    .state     (state)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against any accidental hang in the stimulus sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    testsRun++;
    if (obs != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState   = MS_IDLE;
    mDur     = 0;
    mElapsed = 0;
    mPhot    = 0;
    mClrLeft = 0;
    eStart   = 0;
    eStop    = 0;
    eDone    = 0;
    eErr     = 0;
  endtask

  // Run-level reference: what one clock edge does to the measurement run.
  task automatic modelStep(input bit v, input int op, input int d, input bit tk, input bit s);
    bit acc;
    bit reachedEnd;
    int prevEl;
    eStart = 0;
    eStop  = 0;
    eDone  = 0;
    eErr   = 0;
    acc    = v && (mState != MS_CLEAR);
    prevEl = mElapsed;
    reachedEnd = 0;
    if (mState == MS_RUN) begin
      if (tk) mElapsed = (mElapsed < MAXT) ? mElapsed + 1 : MAXT;
      if (s && PHOT_EN) mPhot = (mPhot < MAXC) ? mPhot + 1 : MAXC;
      reachedEnd = tk && (mDur != 0) && (prevEl + 1 == mDur);
    end
    case (mState)
      MS_IDLE: begin
        if (acc && op == OP_START) begin
          mDur     = d;
          mElapsed = 0;
          mPhot    = 0;
          mClrLeft = CLR;
          mState   = MS_CLEAR;
        end else if (acc && op == OP_STOP) begin
          eErr = 1;
        end
      end
      MS_CLEAR: begin
        mClrLeft = mClrLeft - 1;
        if (mClrLeft == 0) begin
          mState = MS_RUN;
          eStart = 1;
        end
      end
      MS_RUN: begin
        if (reachedEnd) begin
          eStop  = 1;
          eDone  = 1;
          mState = MS_HOLD;
        end
        if (acc && op == OP_START) eErr = 1;
        if (acc && op == OP_STOP) begin
          eStop  = 1;
          mState = MS_HOLD;
        end
        if (acc && op == OP_ABORT) begin
          eStop    = 1;
          eDone    = 0;
          mElapsed = 0;
          mPhot    = 0;
          mState   = MS_IDLE;
        end
      end
      default: begin
        if (acc && op == OP_START) begin
          if (mDur != 0 && mElapsed >= mDur) begin
            eErr = 1;
          end else begin
            eStart = 1;
            mState = MS_RUN;
          end
        end else if (acc && op == OP_STOP) begin
          eErr = 1;
        end else if (acc && op == OP_ABORT) begin
          mElapsed = 0;
          mPhot    = 0;
          mState   = MS_IDLE;
        end
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("state", state, mState);
    checkOutput("clr", clr, mState == MS_CLEAR);
    checkOutput("running", running, mState == MS_RUN);
    checkOutput("start", startP, eStart);
    checkOutput("stop", stopP, eStop);
    checkOutput("done", done, eDone);
    checkOutput("cmdErr", cmdErr, eErr);
    checkOutput("elapsed", elapsed, mElapsed);
    checkOutput("photonCnt", photonCnt, mPhot);
  endtask

  // Drives one cycle of inputs, advances the model and checks the registered outputs after the edge.
  task automatic applyStimulus(input bit v, input int op, input int d, input bit tk, input bit s);
    cmdValid = v;
    cmdOp    = op[1:0];
    dur      = d[TW-1:0];
    tick     = tk;
    sin      = s;
    #1;
    checkOutput("cmdReady", cmdReady, mState != MS_CLEAR);
    modelStep(v, op, d, tk, s);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("rstState", state, MS_IDLE);
    checkOutput("rstClr", clr, 0);
    checkOutput("rstCmdReady", cmdReady, 1);
    checkOutput("rstRunning", running, 0);
    checkOutput("rstStop", stopP, 0);
    checkOutput("rstElapsed", elapsed, 0);
    checkOutput("rstPhoton", photonCnt, 0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, OP_NOP, 0, 0, 0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cmdValid = 0;
    cmdOp    = '0;
    dur      = '0;
    tick     = 0;
    sin      = 0;
    rstN     = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    // Timed run: clear sweep, then auto-stop after the programmed ticks.
    applyStimulus(1, OP_START, 5, 0, 0);
    idleCycles(CLR);
    checkOutput("runStart", startP, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, OP_NOP, 0, 1, 0);
    checkOutput("autoStopDone", done, 1);
    checkOutput("autoStopElapsed", elapsed, 5);
    checkOutput("autoStopState", state, MS_HOLD);
    applyStimulus(1, OP_START, 0, 0, 0);
    checkOutput("resumeAfterEndErr", cmdErr, 1);
    applyStimulus(1, OP_ABORT, 0, 0, 0);
    applyStimulus(1, OP_STOP, 0, 0, 0);
    checkOutput("stopInIdleErr", cmdErr, 1);
    applyStimulus(0, OP_NOP, 0, 0, 0);

    // Unlimited run with photons, manual stop, resume, and abort.
    applyStimulus(1, OP_START, 0, 0, 0);
    idleCycles(CLR);
    for (int i = 0; i < 10; i++) applyStimulus(0, OP_NOP, 0, 0, 1);
    applyStimulus(1, OP_STOP, 0, 0, 0);
    checkOutput("manualStopDone", done, 0);
    checkOutput("holdPhotons", photonCnt, PHOT_EN ? 10 : 0);
    applyStimulus(0, OP_NOP, 0, 1, 1);
    applyStimulus(1, OP_START, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, OP_NOP, 0, 0, 1);
    applyStimulus(1, OP_START, 0, 0, 0);
    checkOutput("startInRunErr", cmdErr, 1);
    applyStimulus(1, OP_ABORT, 0, 0, 0);
    checkOutput("abortStop", stopP, 1);

    // Stop command coinciding with the final tick.
    applyStimulus(1, OP_START, 3, 0, 0);
    idleCycles(CLR);
    applyStimulus(0, OP_NOP, 0, 1, 0);
    applyStimulus(0, OP_NOP, 0, 1, 0);
    applyStimulus(1, OP_STOP, 0, 1, 0);
    checkOutput("coincideDone", done, 1);
    checkOutput("coincideElapsed", elapsed, 3);
    applyStimulus(0, OP_NOP, 0, 0, 0);
    applyStimulus(1, OP_ABORT, 0, 0, 0);

    // Saturation of both counters on an unlimited run.
    applyStimulus(1, OP_START, 0, 0, 0);
    idleCycles(CLR);
    for (int i = 0; i < 20; i++) applyStimulus(0, OP_NOP, 0, 1, 1);
    checkOutput("satElapsed", elapsed, MAXT);
    applyStimulus(1, OP_ABORT, 0, 0, 0);

    // Reset in the middle of the clear sweep.
    applyStimulus(1, OP_START, 2, 0, 0);
    idleCycles(2);
    doReset();
    applyStimulus(0, OP_NOP, 0, 0, 0);

    // Random commands, ticks and photons with occasional asynchronous resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/meas_run_ctrl.md
# meas_run_ctrl

Measurement run controller for the multi-tau correlator. It accepts host commands and drives the single-cycle `start`/`stop` pulses and the multi-cycle `clr` level into the photon-stream gate. It times each run against a programmed duration using an external timebase strobe and counts gated photons. It sits between the host command interface and the correlator input gate.

## Interface
- `TICK_W`, 32, width of duration/elapsed counters (timebase ticks)
- `CNT_W`, 32, width of photon counter
- `CLR_LEN`, 256, cycles `clr` is held high (correlator RAM sweep), ≥1
- `clk` input 1 clock
- `rst_n` input 1 asynchronous, active-low reset
- `cmd_valid` input 1 command present
- `cmd_ready` output 1 command can be accepted
- `cmd_op` input 2 00 nop, 01 start/resume, 10 stop, 11 abort
- `duration` input TICK_W run length in ticks, latched on fresh start; 0 = unlimited
- `tick` input 1 timebase strobe, one cycle wide
- `sin` input 1 photon pulse, synchronous, one cycle per photon
- `start` output 1 one-cycle pulse to gate
- `stop` output 1 one-cycle pulse to gate
- `clr` output 1 clear level to gate/correlator
- `running` output 1 state == RUN
- `done` output 1 one-cycle pulse on auto-stop
- `cmd_err` output 1 one-cycle pulse on illegal command
- `elapsed` output TICK_W ticks counted in current run
- `photon_cnt` output CNT_W photons counted in current run
- `state` output 2 IDLE=0, CLEAR=1, RUN=2, HOLD=3

## Operation
- Command accepted when `cmd_valid && cmd_ready`; `cmd_ready` = (state != CLEAR), combinational from state.
- IDLE: start → latch `duration`, zero `elapsed`/`photon_cnt`, go CLEAR. Stop → `cmd_err`, ignored.
- CLEAR: `clr`=1 for exactly CLR_LEN cycles, then go RUN with `start` pulse. Commands not accepted.
- RUN: `tick` increments `elapsed`; `sin` increments `photon_cnt`. Stop cmd → `stop` pulse, HOLD. Auto-stop when latched duration≠0 and a `tick` arrives with `elapsed == duration-1`: `elapsed` becomes duration, `stop` + `done` pulse, HOLD. Start cmd → `cmd_err`.
- HOLD: counters frozen. Start → `start` pulse, RUN, counters continue. Start is rejected with `cmd_err` if duration≠0 and `elapsed ≥ duration`. Stop → `cmd_err`.
- Abort (11) from IDLE/RUN/HOLD: `stop` pulse if leaving RUN, zero counters, go IDLE. Abort during CLEAR is not possible (`cmd_ready`=0).
- Stop cmd and auto-stop in the same cycle: single `stop` pulse, `done`=1.
- Counters saturate at all-ones, with no wrap.

## Timing
- Reset: state IDLE; `start`,`stop`,`clr`,`done`,`cmd_err`=0; `elapsed`,`photon_cnt`=0; `running`=0; `cmd_ready`=1. A reset mid-run has the same effect immediately and emits no `stop` pulse.
- All outputs registered except `cmd_ready`.
- Start accepted at edge N in IDLE: `clr` high in cycles N+1 … N+CLR_LEN; `start` and `running` high at N+CLR_LEN+1.
- Stop/resume/abort accepted at edge N: pulse and new state visible at N+1.
- `sin` and `tick` are counted in every cycle where registered state == RUN, including the cycle a stop is accepted or auto-stop fires.
- `cmd_err` asserts one cycle after the offending command.

## Configuration
- `MEAS_RUN_CTRL_PHOTON_CNT_EN` defined: photon counter present as above.
- Not defined: `sin` ignored, `photon_cnt` tied to 0, and the counter logic is removed. All other behaviour is unchanged.

## Test plan
- Reset, then start with duration=5 and CLR_LEN=4: `clr` high for 4 cycles, `start` pulse on the 5th. After 5 ticks: `stop`+`done` pulse, `elapsed`=5, state HOLD.
- Unlimited run (duration=0), 10 `sin` pulses, stop cmd: `photon_cnt`=10, single `stop`, no `done`. Resume: `start` pulse, counts continue from 10.
- Stop cmd in the same cycle as the final tick: exactly one `stop`, `done`=1, `elapsed`=duration.
- Stop in IDLE, start in RUN, and resume after auto-stop each produce `cmd_err`=1 for one cycle with no state change.
- Abort in RUN: `stop` pulse, counters 0, state IDLE. Assert `rst_n` low mid-CLEAR: `clr`=0 immediately, state IDLE, and `cmd_ready`=1.
